// File: rtl/joystick_pkg.sv
// Shared FSM encoding and counter-width helper for the serial joystick reader.
package joystick_pkg;

    typedef enum logic [1:0] {
        StLoad,
        StShift,
        StLatch,
        StGap
    } state_t;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/joystick_sr_ce.sv
// Half-period enable: divider counts 0..DIV-1, pulses ce on the wrap cycle, first on count 0.
module joystick_sr_ce
    import joystick_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    output logic ce,
    output logic first
);

    localparam int unsigned DW = cnt_w(DIV);

    logic [DW-1:0] div_q;

    assign ce    = (div_q == DW'(DIV - 1));
    assign first = (div_q == '0);

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            div_q <= '0;
        end else if (ce) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

endmodule

// File: rtl/joystick_sr.sv
// Serial reader for a daisy-chained 74HC165 joystick chain with frame strobe.
// Optional frame debouncing when JOYSTICK_DEBOUNCE_EN is defined.
module joystick_sr
    import joystick_pkg::*;
#(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned BITS     = 8,
    parameter int unsigned DIV      = 4,
    parameter int unsigned GAP      = 2,
    parameter int unsigned INVERT   = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       joyCk,
    output logic                       joyLd,
    input  logic                       joyD,
    output logic [CHANNELS*BITS-1:0]   joy,
    output logic                       strb
);

    localparam int unsigned N  = CHANNELS * BITS;
    localparam int unsigned BW = cnt_w(N);
    localparam int unsigned HW = cnt_w((GAP > 2) ? GAP : 2);

    state_t          state_q;
    logic [BW-1:0]   bit_q;
    logic [HW-1:0]   half_q;
    logic            phase_q;
    logic [N-1:0]    sr_q;
    logic [N-1:0]    joy_q;
    logic [N-1:0]    frame;
    logic            ck_q;
    logic            ld_q;
    logic            strb_q;
    logic            ce;
    logic            first;
    logic            clr;
`ifdef JOYSTICK_DEBOUNCE_EN
    logic [N-1:0]    prev_q;
`endif

    // The divider restarts after the single-cycle LATCH so GAP is a whole number of half-periods.
    assign clr = (state_q == StLatch);

    joystick_sr_ce #(
        .DIV(DIV)
    ) u_ce (
        .clock(clock),
        .reset(reset),
        .clr  (clr),
        .ce   (ce),
        .first(first)
    );

    assign frame = (INVERT != 0) ? ~sr_q : sr_q;

    assign joyCk = ck_q;
    assign joyLd = ld_q;
    assign joy   = joy_q;
    assign strb  = strb_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StLoad;
            bit_q   <= '0;
            half_q  <= '0;
            phase_q <= 1'b0;
            sr_q    <= '0;
            joy_q   <= '0;
            ck_q    <= 1'b1;
            ld_q    <= 1'b1;
            strb_q  <= 1'b0;
`ifdef JOYSTICK_DEBOUNCE_EN
            prev_q  <= '0;
`endif
        end else begin
            ck_q   <= !(state_q == StShift && !phase_q);
            ld_q   <= !(state_q == StLoad);
            strb_q <= (state_q == StLatch);
            case (state_q)
                StLoad: begin
                    if (ce) begin
                        if (half_q == HW'(1)) begin
                            half_q  <= '0;
                            phase_q <= 1'b0;
                            bit_q   <= '0;
                            state_q <= StShift;
                        end else begin
                            half_q <= half_q + HW'(1);
                        end
                    end
                end
                StShift: begin
                    // Outputs lag state by one cycle, so the first high-phase state cycle is
                    // the last cycle joyCk is low on the wire.
                    if (phase_q && first) begin
                        sr_q <= {sr_q[N-2:0], joyD};
                    end
                    if (ce) begin
                        if (!phase_q) begin
                            phase_q <= 1'b1;
                        end else begin
                            phase_q <= 1'b0;
                            if (bit_q == BW'(N - 1)) begin
                                bit_q   <= '0;
                                state_q <= StLatch;
                            end else begin
                                bit_q <= bit_q + BW'(1);
                            end
                        end
                    end
                end
                StLatch: begin
`ifdef JOYSTICK_DEBOUNCE_EN
                    if (frame == prev_q) begin
                        joy_q <= frame;
                    end
                    prev_q <= frame;
`else
                    joy_q <= frame;
`endif
                    half_q  <= '0;
                    state_q <= StGap;
                end
                StGap: begin
                    if (ce) begin
                        if (half_q == HW'(GAP - 1)) begin
                            half_q  <= '0;
                            state_q <= StLoad;
                        end else begin
                            half_q <= half_q + HW'(1);
                        end
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

endmodule
